// File: rtl/tt_pg_ctrl_pkg.sv
// Purpose: shared types, default dwell constants and per-state output decode for the power-gate sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional feature macro: TT_PG_PWRGOOD_EN (affects tt_pg_ctrl_seq only).
package tt_pg_ctrl_pkg;

  typedef enum logic [2:0] {
    OFF,
    RAMP,
    RST_REL,
    ON,
    ISO,
    RST_ASSERT
  } pg_state_e;

  localparam int DEF_CNT_W          = 8;
  localparam int DEF_RAMP_CYCLES    = 64;
  localparam int DEF_RST_CYCLES     = 4;
  localparam int DEF_ISO_CYCLES     = 4;
  localparam int DEF_OFF_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Pins driven straight from state; busy and err need history so live elsewhere.
  typedef struct packed {
    logic pg_ctrl;
    logic dom_rst;
    logic iso_n;
    logic pwr_on;
  } pg_out_t;

  localparam pg_out_t OUT_OFF     = '{pg_ctrl: 1'b0, dom_rst: 1'b1, iso_n: 1'b0, pwr_on: 1'b0};
  localparam pg_out_t OUT_RAMP    = '{pg_ctrl: 1'b1, dom_rst: 1'b1, iso_n: 1'b0, pwr_on: 1'b0};
  localparam pg_out_t OUT_RST_REL = '{pg_ctrl: 1'b1, dom_rst: 1'b0, iso_n: 1'b0, pwr_on: 1'b0};
  localparam pg_out_t OUT_ON      = '{pg_ctrl: 1'b1, dom_rst: 1'b0, iso_n: 1'b1, pwr_on: 1'b1};
  localparam pg_out_t OUT_ISO     = '{pg_ctrl: 1'b1, dom_rst: 1'b0, iso_n: 1'b0, pwr_on: 1'b0};
  localparam pg_out_t OUT_RST_AS  = '{pg_ctrl: 1'b1, dom_rst: 1'b1, iso_n: 1'b0, pwr_on: 1'b0};

  // Unknown encodings fall back to the safe powered-off pattern.
  function automatic pg_out_t state_out(input pg_state_e s);
    case (s)
      OFF:        return OUT_OFF;
      RAMP:       return OUT_RAMP;
      RST_REL:    return OUT_RST_REL;
      ON:         return OUT_ON;
      ISO:        return OUT_ISO;
      RST_ASSERT: return OUT_RST_AS;
      default:    return OUT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tt_pg_ctrl_seq_if.sv
// Purpose: request/status bundle between mux control logic (master) and the power-gate sequencer (slave).
// Latency: n/a (wiring only).
// Backpressure: none; en_req is a level request. pwr_good/err exist only with TT_PG_PWRGOOD_EN.
interface tt_pg_ctrl_seq_if;

  logic en_req;
  logic pg_ctrl;
  logic dom_rst;
  logic iso_n;
  logic pwr_on;
  logic busy;
`ifdef TT_PG_PWRGOOD_EN
  logic pwr_good;
  logic err;

  modport master (output en_req, output pwr_good,
                  input pg_ctrl, input dom_rst, input iso_n, input pwr_on, input busy, input err);
  modport slave  (input en_req, input pwr_good,
                  output pg_ctrl, output dom_rst, output iso_n, output pwr_on, output busy, output err);
`else
  modport master (output en_req,
                  input pg_ctrl, input dom_rst, input iso_n, input pwr_on, input busy);
  modport slave  (input en_req,
                  output pg_ctrl, output dom_rst, output iso_n, output pwr_on, output busy);
`endif

endinterface

// File: rtl/tt_pg_sync2.sv
// Purpose: 2-FF synchronizer for the asynchronous pwr_good sense; exists only with TT_PG_PWRGOOD_EN.
// Latency: 2 clk cycles from a stable input to q.
// Backpressure: none.
`ifdef TT_PG_PWRGOOD_EN
module tt_pg_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the sample one stage per clock.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages; reset reads as "power not good".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`endif

// File: rtl/tt_pg_ctrl_seq.sv
// Purpose: sequences power switch, domain reset and isolation for one gated domain (macro TT_PG_PWRGOOD_EN adds pwr_good gating + err).
// Latency: outputs registered; power-up RAMP+RST cycles after en_req rise, power-down ISO+RST cycles after fall.
// Backpressure: en_req is only honoured in ON or dwell-expired OFF; busy flags when a request would be deferred.
module tt_pg_ctrl_seq
  import tt_pg_ctrl_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int RAMP_CYCLES    = DEF_RAMP_CYCLES,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int ISO_CYCLES     = DEF_ISO_CYCLES,
  parameter int OFF_CYCLES     = DEF_OFF_CYCLES
`ifdef TT_PG_PWRGOOD_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             rst,
  tt_pg_ctrl_seq_if.slave  bus
);

  // Counter holds "cycles left minus one"; a state exits on the edge where it reads zero.
`ifdef TT_PG_PWRGOOD_EN
  // RAMP counts down from the timeout; the minimum ramp has elapsed once cnt <= RAMP_LEFT.
  localparam logic [CNT_W-1:0] LD_RAMP   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAMP_LEFT = CNT_W'(TIMEOUT_CYCLES - RAMP_CYCLES);
`else
  localparam logic [CNT_W-1:0] LD_RAMP   = CNT_W'(RAMP_CYCLES - 1);
`endif
  localparam logic [CNT_W-1:0] LD_RST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_ISO = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_OFF = CNT_W'(OFF_CYCLES - 1);

  pg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pg_out_t          out_q, out_d;
  logic             busy_q, busy_d;
  logic             cnt_zero;

`ifdef TT_PG_PWRGOOD_EN
  logic err_q, err_d;
  logic pwr_good_s;
  logic timeout;

  tt_pg_sync2 u_pwr_good_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pwr_good),
    .q   (pwr_good_s)
  );
`endif

  assign cnt_zero = (cnt_q == '0);

  // State, dwell counter and output registers; reset drops power at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      out_q   <= OUT_OFF;
      busy_q  <= 1'b0;
`ifdef TT_PG_PWRGOOD_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
`ifdef TT_PG_PWRGOOD_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next state: en_req only matters in ON and in a dwell-expired OFF.
  always_comb begin
    state_d = state_q;
`ifdef TT_PG_PWRGOOD_EN
    timeout = 1'b0;
`endif
    case (state_q)
      OFF:        if (cnt_zero && bus.en_req) state_d = RAMP;
`ifdef TT_PG_PWRGOOD_EN
      RAMP: begin
        if (pwr_good_s && (cnt_q <= RAMP_LEFT)) begin
          state_d = RST_REL;
        end else if (cnt_zero) begin
          state_d = RST_ASSERT;
          timeout = 1'b1;
        end
      end
`else
      RAMP:       if (cnt_zero) state_d = RST_REL;
`endif
      RST_REL:    if (cnt_zero) state_d = ON;
      ON:         if (!bus.en_req) state_d = ISO;
      ISO:        if (cnt_zero) state_d = RST_ASSERT;
      RST_ASSERT: if (cnt_zero) state_d = OFF;
      default:    state_d = OFF;
    endcase
  end

  // Dwell reload on entry, output decode of the state being entered, busy/err bookkeeping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        RAMP:       cnt_d = LD_RAMP;
        RST_REL:    cnt_d = LD_RST;
        RST_ASSERT: cnt_d = LD_RST;
        ISO:        cnt_d = LD_ISO;
        OFF:        cnt_d = LD_OFF;
        default:    cnt_d = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    out_d = state_out(state_d);

    // Staying in OFF with the counter already at zero means the full dwell has passed.
    if (state_d == OFF) begin
      busy_d = !((state_q == OFF) && cnt_zero);
    end else begin
      busy_d = (state_d != ON);
    end

`ifdef TT_PG_PWRGOOD_EN
    err_d = err_q;
    if (timeout) begin
      err_d = 1'b1;
    end else if ((state_d == ON) && (state_q != ON)) begin
      err_d = 1'b0;
    end
`endif
  end

  assign bus.pg_ctrl = out_q.pg_ctrl;
  assign bus.dom_rst = out_q.dom_rst;
  assign bus.iso_n   = out_q.iso_n;
  assign bus.pwr_on  = out_q.pwr_on;
  assign bus.busy    = busy_q;
`ifdef TT_PG_PWRGOOD_EN
  assign bus.err     = err_q;
`endif

endmodule

// File: tb/tb_tt_pg_ctrl_seq.sv
// Purpose: directed bench for tt_pg_ctrl_seq with a schedule-based reference model (TT_PG_PWRGOOD_EN adds pwr_good cases).
// Latency: expectations are counted in edges after the one that samples en_req.
// Backpressure: n/a.
module tb_tt_pg_ctrl_seq;

  localparam int RAMP_C = 8;
  localparam int RST_C  = 2;
  localparam int ISO_C  = 2;
  localparam int OFF_C  = 4;

  // Vector order: {pg_ctrl, dom_rst, iso_n, pwr_on, busy}
  localparam logic [4:0] V_IDLE_DN = 5'b01000;
  localparam logic [4:0] V_RAMP    = 5'b11001;
  localparam logic [4:0] V_RREL    = 5'b10001;
  localparam logic [4:0] V_ON      = 5'b10110;
  localparam logic [4:0] V_ISO     = 5'b10001;
  localparam logic [4:0] V_RSTA    = 5'b11001;
  localparam logic [4:0] V_OFFW    = 5'b01001;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  bit   chk_en;

  tt_pg_ctrl_seq_if pg_if ();

  tt_pg_ctrl_seq #(
    .CNT_W          (8),
    .RAMP_CYCLES    (RAMP_C),
    .RST_CYCLES     (RST_C),
    .ISO_CYCLES     (ISO_C),
    .OFF_CYCLES     (OFF_C)
`ifdef TT_PG_PWRGOOD_EN
    ,
    .TIMEOUT_CYCLES (255)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (pg_if)
  );

  wire [4:0] dut_v = {pg_if.pg_ctrl, pg_if.dom_rst, pg_if.iso_n, pg_if.pwr_on, pg_if.busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Reference model: once a request is accepted, the whole waveform is queued ahead;
  // en_req is looked at only when nothing is left to play out.
  logic [4:0] exp_v;
  logic [4:0] sched[$];
  bit         up;

  initial begin
    exp_v = V_IDLE_DN;
    up    = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sched.delete();
        up    = 1'b0;
        exp_v = V_IDLE_DN;
      end else begin
        if (sched.size() == 0) begin
          if (!up && pg_if.en_req) begin
            for (int i = 0; i < RAMP_C; i++) sched.push_back(V_RAMP);
            for (int i = 0; i < RST_C; i++)  sched.push_back(V_RREL);
            sched.push_back(V_ON);
            up = 1'b1;
          end else if (up && !pg_if.en_req) begin
            for (int i = 0; i < ISO_C; i++) sched.push_back(V_ISO);
            for (int i = 0; i < RST_C; i++) sched.push_back(V_RSTA);
            for (int i = 0; i < OFF_C; i++) sched.push_back(V_OFFW);
            up = 1'b0;
          end
        end
        if (sched.size() != 0) exp_v = sched.pop_front();
        else                   exp_v = up ? V_ON : V_IDLE_DN;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare against the model.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      chk("model", {3'b000, dut_v}, {3'b000, exp_v});
`ifdef TT_PG_PWRGOOD_EN
      chk("model_err", {7'd0, pg_if.err}, 8'd0);
`endif
    end
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    n_chk         = 0;
    n_err         = 0;
    chk_en        = 1'b0;
    rst           = 1'b0;
    pg_if.en_req  = 1'b0;
`ifdef TT_PG_PWRGOOD_EN
    pg_if.pwr_good = 1'b1;
`endif

    // Async reset off the clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd0);
    chk("rst_dom_rst", {7'd0, pg_if.dom_rst}, 8'd1);
    chk("rst_iso_n",   {7'd0, pg_if.iso_n},   8'd0);
    chk("rst_pwr_on",  {7'd0, pg_if.pwr_on},  8'd0);
    chk("rst_busy",    {7'd0, pg_if.busy},    8'd0);
    cycn(3);
    rst    = 1'b0;
    chk_en = 1'b1;
    cycn(2);

    // Power-up; edge 0 samples en_req=1.
    pg_if.en_req = 1'b1;
    cyc();
    chk("up_e0_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd1);
    chk("up_e0_busy",    {7'd0, pg_if.busy},    8'd1);
    cycn(7);
    chk("up_e7_dom_rst", {7'd0, pg_if.dom_rst}, 8'd1);
    cyc();
    chk("up_e8_dom_rst", {7'd0, pg_if.dom_rst}, 8'd0);
    chk("up_e8_iso_n",   {7'd0, pg_if.iso_n},   8'd0);
    cyc();
    chk("up_e9_busy",    {7'd0, pg_if.busy},    8'd1);
    cyc();
    chk("up_e10_iso_n",  {7'd0, pg_if.iso_n},   8'd1);
    chk("up_e10_pwr_on", {7'd0, pg_if.pwr_on},  8'd1);
    chk("up_e10_busy",   {7'd0, pg_if.busy},    8'd0);
    cycn(3);

    // Power-down; edge e samples en_req=0.
    pg_if.en_req = 1'b0;
    cyc();
    chk("dn_e_iso_n",    {7'd0, pg_if.iso_n},   8'd0);
    chk("dn_e_pwr_on",   {7'd0, pg_if.pwr_on},  8'd0);
    chk("dn_e_dom_rst",  {7'd0, pg_if.dom_rst}, 8'd0);
    cycn(2);
    chk("dn_e2_dom_rst", {7'd0, pg_if.dom_rst}, 8'd1);
    chk("dn_e2_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd1);
    cycn(2);
    chk("dn_e4_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd0);
    cycn(3);
    chk("dn_e7_busy",    {7'd0, pg_if.busy},    8'd1);
    cyc();
    chk("dn_e8_busy",    {7'd0, pg_if.busy},    8'd0);
    cycn(2);

    // Request withdrawn during RAMP: power-up still completes, then powers down.
    pg_if.en_req = 1'b1;
    cycn(3);
    pg_if.en_req = 1'b0;
    cycn(8);
    chk("abort_e10_pwr_on", {7'd0, pg_if.pwr_on}, 8'd1);
    cyc();
    chk("abort_e11_pwr_on", {7'd0, pg_if.pwr_on}, 8'd0);
    chk("abort_e11_iso_n",  {7'd0, pg_if.iso_n},  8'd0);
    chk("abort_e11_busy",   {7'd0, pg_if.busy},   8'd1);
    cycn(8);
    chk("abort_e19_busy",    {7'd0, pg_if.busy},    8'd0);
    chk("abort_e19_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd0);
    cycn(2);

    // OFF dwell: request re-raised during power-down waits out the full dwell.
    pg_if.en_req = 1'b1;
    cycn(11);
    chk("dwell_on", {7'd0, pg_if.pwr_on}, 8'd1);
    pg_if.en_req = 1'b0;
    cyc();
    pg_if.en_req = 1'b1;
    cycn(4);
    chk("dwell_e4_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd0);
    cycn(3);
    chk("dwell_e7_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd0);
    chk("dwell_e7_busy",    {7'd0, pg_if.busy},    8'd1);
    cyc();
    chk("dwell_e8_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd1);
    chk("dwell_e8_dom_rst", {7'd0, pg_if.dom_rst}, 8'd1);
    cycn(10);
    chk("dwell_e18_pwr_on", {7'd0, pg_if.pwr_on},  8'd1);

    // Reset in the middle of a power-down cuts power immediately.
    pg_if.en_req = 1'b0;
    cycn(2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd0);
    chk("midrst_dom_rst", {7'd0, pg_if.dom_rst}, 8'd1);
    chk("midrst_iso_n",   {7'd0, pg_if.iso_n},   8'd0);
    chk("midrst_busy",    {7'd0, pg_if.busy},    8'd0);
    cyc();
    rst = 1'b0;
    cycn(2);
    pg_if.en_req = 1'b1;
    cyc();
    chk("postrst_e0_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd1);
    cycn(10);
    chk("postrst_e10_pwr_on", {7'd0, pg_if.pwr_on}, 8'd1);

`ifdef TT_PG_PWRGOOD_EN
    pg_if.en_req = 1'b0;
    cycn(10);
    chk_en = 1'b0;

    // pwr_good never arrives: timeout at RAMP cycle 255.
    pg_if.pwr_good = 1'b0;
    cycn(3);
    pg_if.en_req = 1'b1;
    cyc();
    pg_if.en_req = 1'b0;
    cycn(254);
    chk("to_e254_dom_rst", {7'd0, pg_if.dom_rst}, 8'd1);
    chk("to_e254_err",     {7'd0, pg_if.err},     8'd0);
    cyc();
    chk("to_e255_err",     {7'd0, pg_if.err},     8'd1);
    chk("to_e255_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd1);
    chk("to_e255_dom_rst", {7'd0, pg_if.dom_rst}, 8'd1);
    cycn(2);
    chk("to_e257_pg_ctrl", {7'd0, pg_if.pg_ctrl}, 8'd0);
    cycn(4);
    chk("to_e261_busy",    {7'd0, pg_if.busy},    8'd0);
    chk("to_e261_err",     {7'd0, pg_if.err},     8'd1);

    // Early pwr_good does not shorten the minimum ramp; err clears on ON.
    pg_if.en_req = 1'b1;
    cycn(3);
    pg_if.pwr_good = 1'b1;
    cycn(5);
    chk("pg_e7_dom_rst",  {7'd0, pg_if.dom_rst}, 8'd1);
    cyc();
    chk("pg_e8_dom_rst",  {7'd0, pg_if.dom_rst}, 8'd0);
    cycn(2);
    chk("pg_e10_pwr_on",  {7'd0, pg_if.pwr_on},  8'd1);
    chk("pg_e10_err",     {7'd0, pg_if.err},     8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_pg_ctrl_seq.md
Name: tt_pg_ctrl_seq

Overview:
- Controller that drives the `ctrl` pin of the 1v8 power-gate cell, i.e. the `GPWR` enable for one gated user domain.
- Sequences switch enable, domain reset and output isolation in a fixed, timed order for power-up and power-down.
- Sits in the always-on domain next to the power switch; takes a single level request from the mux control logic.

Parameters:
- CNT_W, 8: dwell counter width; every *_CYCLES value must be 1..2^CNT_W-1.
- RAMP_CYCLES, 64: cycles `pg_ctrl` stays high before domain reset is released.
- RST_CYCLES, 4: cycles between a `dom_rst` edge and the next step, in both directions.
- ISO_CYCLES, 4: cycles isolation is held before `dom_rst` is reasserted on power-down.
- OFF_CYCLES, 16: minimum dwell in OFF before a new power-up is honoured.
- TIMEOUT_CYCLES, 255: used only with TT_PG_PWRGOOD_EN; must be ≥ RAMP_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en_req  input  1  level request; 1 = domain powered, 0 = domain off.
- pg_ctrl  output  1  to the power-gate `ctrl` pin; 1 = `GPWR` connected to `VPWR`.
- dom_rst  output  1  gated-domain reset; 1 = held in reset.
- iso_n  output  1  0 = domain outputs clamped.
- pwr_on  output  1  1 only in ON (fully up, de-isolated).
- busy  output  1  1 in any state except ON and an OFF whose dwell has expired.
- pwr_good  input  1  only with TT_PG_PWRGOOD_EN; asynchronous, from the switch sense.
- err  output  1  only with TT_PG_PWRGOOD_EN; sticky ramp-timeout flag.

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - On reset, state = OFF with dwell expired.
  - Outputs on reset: `pg_ctrl`=0, `dom_rst`=1, `iso_n`=0, `pwr_on`=0, `busy`=0, `err`=0.
  - Reset asserted mid-sequence cuts power immediately, with no orderly shutdown.
- Outputs are registered and decoded from state, so they change on the edge that enters a state.
- A state with dwell N lasts exactly N cycles, counted by a down-counter loaded on state entry.
- States and transitions:
  - OFF: `pg_ctrl`=0, `dom_rst`=1, `iso_n`=0. Dwell counts OFF_CYCLES after entry from RST_ASSERT. When dwell is expired and `en_req`=1 -> RAMP.
  - RAMP: `pg_ctrl`=1, `dom_rst`=1, `iso_n`=0, `busy`=1. After RAMP_CYCLES -> RST_REL.
  - RST_REL: `pg_ctrl`=1, `dom_rst`=0, `iso_n`=0. After RST_CYCLES -> ON.
  - ON: `pg_ctrl`=1, `dom_rst`=0, `iso_n`=1, `pwr_on`=1, `busy`=0. If `en_req`=0 -> ISO.
  - ISO: `iso_n`=0, `dom_rst`=0, `pg_ctrl`=1. After ISO_CYCLES -> RST_ASSERT.
  - RST_ASSERT: `dom_rst`=1, `iso_n`=0, `pg_ctrl`=1. After RST_CYCLES -> OFF.
- Sequences are atomic: `en_req` is ignored outside OFF and ON. A toggle during a sequence is evaluated only once OFF or ON is reached.
- Latency:
  - `en_req` rise sampled at edge t in idle OFF: `pg_ctrl`=1 after t, `dom_rst`=0 after t+RAMP_CYCLES, `pwr_on`=1 after t+RAMP_CYCLES+RST_CYCLES.
  - `en_req` fall sampled at edge e in ON: `iso_n`=0 and `pwr_on`=0 after e, `dom_rst`=1 after e+ISO_CYCLES, `pg_ctrl`=0 after e+ISO_CYCLES+RST_CYCLES.
- Invariants: `iso_n`=1 implies `pg_ctrl`=1 and `dom_rst`=0. `pg_ctrl`=0 implies `dom_rst`=1 and `iso_n`=0.

Optional Feature:
- Macro TT_PG_PWRGOOD_EN.
- Defined:
  - `pwr_good` passes through a 2-FF synchronizer.
  - RAMP exits to RST_REL only when at least RAMP_CYCLES have elapsed and synchronized `pwr_good`=1.
  - If TIMEOUT_CYCLES elapse in RAMP without that, go to RST_ASSERT and set `err`=1.
  - `err` clears on the next entry to ON, or on `rst`.
- Undefined: RAMP is purely timed; the `pwr_good` and `err` ports and the synchronizer are absent.

Decomposition:
- Package `tt_pg_ctrl_pkg`:
  - State enum: OFF, RAMP, RST_REL, ON, ISO, RST_ASSERT.
  - Default cycle constants.
  - Per-state output-decode constants.
- Sub-module `tt_pg_sync2`: 2-FF synchronizer, instantiated only under TT_PG_PWRGOOD_EN.
- Dwell counter stays inline.

Test Plan:
Bench parameters: RAMP=8, RST=2, ISO=2, OFF=4.
- Reset check: assert `rst` asynchronously mid-clock -> outputs immediately `pg_ctrl`=0, `dom_rst`=1, `iso_n`=0, `pwr_on`=0, `busy`=0.
- Power-up: `en_req`=1 sampled at edge 0 -> `pg_ctrl`=1 after edge 0, `dom_rst`=0 after edge 8, `iso_n`=1 and `pwr_on`=1 after edge 10; `busy`=1 over edges 0..9.
- Power-down: `en_req`=0 sampled at edge e in ON -> `iso_n`=0 after e, `dom_rst`=1 after e+2, `pg_ctrl`=0 after e+4; `busy` stays 1 until after e+8.
- Abort ignored: `en_req` pulses 1 then 0 at cycle 3 of RAMP -> full power-up to ON completes, then power-down starts on the next edge.
- OFF dwell: `en_req`=1 held through power-down -> RAMP re-entered exactly 4 cycles after OFF entry, not earlier.
- With TT_PG_PWRGOOD_EN:
  - `pwr_good` held 0 -> RST_ASSERT entered at RAMP cycle 255, `err`=1, then OFF.
  - `pwr_good`=1 at RAMP cycle 3 -> exit still at cycle 8.
